rv_lsu: RTL and testbench
=========================

// Module: rv_lsu
// PURPOSE
//  Load/store unit downstream of the core's execute stage. Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW
//  request at a time and drives a word-wide, byte-enabled synchronous data RAM.
//  Returns load data with lane extraction and sign/zero extension, or a store completion.
//  Execute stalls on o_req_ready/o_rsp_valid instead of reading the memory array directly.
// PARAMETERS
//  AW       10  data RAM word-address width (1K words); byte-address bits above AW+1 ignored (wrap)
//  MEM_LAT  1   RAM read latency in cycles from o_mem_en to valid i_mem_rdata; legal 1..7
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_rst_n        in   1   reset, asynchronous, active-low
//  i_req_valid    in   1   request offered by execute
//  o_req_ready    out  1   LSU idle; request accepted when valid&ready
//  i_req_we       in   1   1=store, 0=load
//  i_req_funct3   in   3   RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  i_req_addr     in   32  byte address (rs1 + imm, computed by execute)
//  i_req_wdata    in   32  store data (rs2), low bits used for B/H
//  i_req_rd       in   5   load destination, echoed back
//  o_rsp_valid    out  1   response pending
//  i_rsp_ready    in   1   execute consumes response
//  o_rsp_rdata    out  32  extended load data; 0 for stores and errors
//  o_rsp_rd       out  5   echoed rd
//  o_rsp_err      out  1   illegal funct3 (or misalignment, see CONFIGURATION)
//  o_mem_en       out  1   RAM access strobe, exactly one cycle per access
//  o_mem_we       out  1   RAM write
//  o_mem_be       out  4   byte enables, bit n = byte lane n (little-endian)
//  o_mem_addr     out  AW  word address = addr[AW+1:2]
//  o_mem_wdata    out  32  lane-replicated store data
//  i_mem_rdata    in   32  RAM read word
// BEHAVIOUR
//  - Reset: state IDLE; o_req_ready=1; o_rsp_valid, o_rsp_err, o_mem_en, o_mem_we=0;
//    o_mem_be, o_mem_addr, o_mem_wdata, o_rsp_rdata, o_rsp_rd=0.
//  - FSM IDLE -> ISSUE -> (WAIT, loads only) -> RESP -> IDLE. o_req_ready=1 only in IDLE.
//  - Accept at cycle T latches addr/funct3/we/wdata/rd; req inputs ignored outside IDLE.
//  - ISSUE (T+1): o_mem_en=1, o_mem_we=we, be/addr/wdata valid. Store -> RESP at T+2.
//  - WAIT: MEM_LAT cycles, counter counts down; i_mem_rdata sampled on last WAIT cycle.
//    Load o_rsp_valid first at T+2+MEM_LAT (T+3 for MEM_LAT=1).
//  - Illegal funct3 (011, 110, 111; 1xx for stores): ISSUE skipped, no RAM strobe,
//    RESP at T+1 with err=1, rdata=0.
//  - Lanes: B be=1<<a[1:0], wdata={4{d[7:0]}}; H be=a[1]?1100:0011, wdata={2{d[15:0]}};
//    W be=1111, wdata=d. Loads select byte a[1:0] / half a[1]; B/H sign-extend, BU/HU zero-extend.
//  - RESP: outputs held stable until i_rsp_ready; leave RESP on valid&ready, IDLE next cycle
//    (no same-cycle re-accept; max throughput one store per 3 cycles).
//  - i_rst_n low mid-operation: FSM to IDLE asynchronously, o_mem_en drops immediately;
//    pending request and response are lost; no partial write issued after reset.
//  - Address wrap: bits [31:AW+2] ignored; no bus error.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H/HU/SH with a[0]=1, or W/SW with a[1:0]!=0, gives
//    err=1, rdata=0, no RAM strobe, RESP at T+1.
//  Not defined: low address bits forced to natural alignment (H clears a[0], W clears a[1:0]);
//    access proceeds normally with err=0.
// STRUCTURE
//  rv_pkg.vh (shared include): funct3 constants F3_B/H/W/BU/HU, LSU state encodings,
//    opcode constants OP_LOAD/OP_STORE also used by execute.
//  Sub-module rv_lsu_align (combinational): funct3 + addr[1:0] + data -> be, wdata,
//    extended rdata, misaligned flag. FSM, latency counter and handshake stay in rv_lsu.
// TESTING
//  1. SW 0x00000539 @0x0, then LW @0x0 -> store rsp T+2; be=1111; load rdata=0x539, rd echoed.
//  2. Mem[1]=0x80FF7F01; LB @0x5 -> 0x0000007F; LB @0x7 -> 0xFFFFFF80;
//     LBU @0x7 -> 0x80; LH @0x6 -> 0xFFFF80FF.
//  3. SB 0xAB @0x9 -> be=0010, wdata=0xABABABAB; SH 0x1234 @0xA -> be=1100, wdata=0x12341234.
//  4. LH @0x3 -> with LSU_MISALIGN_TRAP_EN: err=1, o_mem_en never high;
//     without: word 0 read, upper half returned.
//  5. funct3=011 load -> err=1, rdata=0, o_rsp_valid at T+1; hold i_rsp_ready=0 for 5 cycles ->
//     outputs stable, o_req_ready=0.
//  6. MEM_LAT=3 load: rsp at T+5; i_rst_n pulsed during WAIT -> o_rsp_valid=0,
//     o_req_ready=1, no RAM write, next request served normally.

Source files
------------

// File: rtl/rv_lsu_pkg.sv
// Shared RV32 load/store definitions: funct3 codes, opcodes and LSU FSM state encodings.
package rv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } lsu_state_e;

  // Stores only exist as B/H/W; unsigned variants are load-only.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// Execute-side request/response handshake plus the data RAM port of the load/store unit.
interface rv_lsu_if #(
  parameter int unsigned AW = 10
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [4:0]    req_rd;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [4:0]    rsp_rd;
  logic          rsp_err;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  // LSU view.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  // Execute stage plus RAM view.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv_lsu_align.sv
// Byte-lane steering for the LSU: store byte enables/replication, load extraction/extension,
// and natural-alignment check.
module rv_lsu_align
  import rv_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Size is funct3[1:0]; the H/W lane choice ignores the low bits below natural alignment.
  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = 32'h0;
    o_misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      2'b10: begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_misaligned = |i_addr_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_addr_lo)
      2'd0:    byte_sel = i_rdata[7:0];
      2'd1:    byte_sel = i_rdata[15:8];
      2'd2:    byte_sel = i_rdata[23:16];
      default: byte_sel = i_rdata[31:24];
    endcase
    half_sel = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_B:    o_rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   o_rdata = {24'h0, byte_sel};
      F3_H:    o_rdata = {{16{half_sel[15]}}, half_sel};
      F3_HU:   o_rdata = {16'h0, half_sel};
      F3_W:    o_rdata = i_rdata;
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: one request at a time into a byte-enabled synchronous data RAM.
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors instead of aligning.
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int unsigned AW      = 10,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  rv_lsu_if.slave  bus
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  lsu_state_e    state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [4:0]    rd_q, rd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          idle, issue;
  logic [2:0]    al_f3;
  logic [1:0]    al_addr_lo;
  logic [31:0]   al_wdata_in, al_wdata, al_rdata;
  logic [3:0]    al_be;
  logic          al_misaligned;
  logic          req_bad;

  assign idle  = (state_q == StIdle);
  assign issue = (state_q == StIssue);

  // In IDLE the aligner looks at the live request so errors can skip ISSUE entirely.
  assign al_f3       = idle ? bus.req_funct3     : f3_q;
  assign al_addr_lo  = idle ? bus.req_addr[1:0]  : addr_q[1:0];
  assign al_wdata_in = idle ? bus.req_wdata      : wdata_q;

  rv_lsu_align u_align (
    .i_funct3     (al_f3),
    .i_addr_lo    (al_addr_lo),
    .i_wdata      (al_wdata_in),
    .i_rdata      (bus.mem_rdata),
    .o_be         (al_be),
    .o_wdata      (al_wdata),
    .o_rdata      (al_rdata),
    .o_misaligned (al_misaligned)
  );

  assign req_bad = f3_illegal(bus.req_we, bus.req_funct3) | (TrapEn & al_misaligned);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr[AW+1:0];
          wdata_d = bus.req_wdata;
          rd_d    = bus.req_rd;
          rdata_d = 32'h0;
          err_d   = req_bad;
          state_d = req_bad ? StResp : StIssue;
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StResp;
        end else begin
          cnt_d   = 3'(MEM_LAT - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          rdata_d = al_rdata;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rd_q    <= 5'd0;
      cnt_q   <= 3'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM port is decoded from state so an async reset drops the strobe immediately.
  assign bus.req_ready = idle;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_rd    = rd_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue & we_q;
  assign bus.mem_be    = issue ? al_be : 4'b0000;
  assign bus.mem_addr  = issue ? addr_q[AW+1:2] : '0;
  assign bus.mem_wdata = issue ? al_wdata : 32'h0;

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu: MEM_LAT=1 and MEM_LAT=3 instances behind one shared stimulus port.
module tb_rv_lsu;
  import rv_lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n1, rst_n3, sel;
  logic        req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;

  logic        m_req_ready, m_rsp_valid, m_rsp_err, m_mem_en, m_mem_we;
  logic [31:0] m_rsp_rdata, m_mem_wdata;
  logic [4:0]  m_rsp_rd;
  logic [3:0]  m_mem_be;
  logic [9:0]  m_mem_addr;

  int   checks = 0;
  int   errors = 0;
  rsp_t sb[$];

  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  logic [9:0]  last_maddr;
  logic        last_we;
  int          wr_cnt3 = 0;

  rv_lsu_if #(.AW(10)) if1 ();
  rv_lsu_if #(.AW(10)) if3 ();

  rv_lsu #(.AW(10), .MEM_LAT(1)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n1), .bus(if1.slave));
  rv_lsu #(.AW(10), .MEM_LAT(3)) u_dut3 (.i_clk(clk), .i_rst_n(rst_n3), .bus(if3.slave));

  assign if1.req_valid  = req_valid & ~sel;
  assign if3.req_valid  = req_valid & sel;
  assign if1.rsp_ready  = rsp_ready & ~sel;
  assign if3.rsp_ready  = rsp_ready & sel;
  assign if1.req_we     = req_we;
  assign if3.req_we     = req_we;
  assign if1.req_funct3 = req_funct3;
  assign if3.req_funct3 = req_funct3;
  assign if1.req_addr   = req_addr;
  assign if3.req_addr   = req_addr;
  assign if1.req_wdata  = req_wdata;
  assign if3.req_wdata  = req_wdata;
  assign if1.req_rd     = req_rd;
  assign if3.req_rd     = req_rd;

  assign m_req_ready = sel ? if3.req_ready : if1.req_ready;
  assign m_rsp_valid = sel ? if3.rsp_valid : if1.rsp_valid;
  assign m_rsp_rdata = sel ? if3.rsp_rdata : if1.rsp_rdata;
  assign m_rsp_rd    = sel ? if3.rsp_rd    : if1.rsp_rd;
  assign m_rsp_err   = sel ? if3.rsp_err   : if1.rsp_err;
  assign m_mem_en    = sel ? if3.mem_en    : if1.mem_en;
  assign m_mem_we    = sel ? if3.mem_we    : if1.mem_we;
  assign m_mem_be    = sel ? if3.mem_be    : if1.mem_be;
  assign m_mem_addr  = sel ? if3.mem_addr  : if1.mem_addr;
  assign m_mem_wdata = sel ? if3.mem_wdata : if1.mem_wdata;

  // RAM models: 1-cycle and 3-cycle read latency, byte-enabled writes.
  bit   [31:0] mem1 [1024];
  bit   [31:0] mem3 [1024];
  logic [31:0] rd1;
  logic [31:0] p3 [3];

  always @(posedge clk) begin
    if (if1.mem_en) begin
      if (if1.mem_we) begin
        for (int i = 0; i < 4; i++)
          if (if1.mem_be[i]) mem1[if1.mem_addr][8*i +: 8] <= if1.mem_wdata[8*i +: 8];
      end else begin
        rd1 <= mem1[if1.mem_addr];
      end
    end
  end
  assign if1.mem_rdata = rd1;

  always @(posedge clk) begin
    p3[0] <= mem3[if3.mem_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (if3.mem_en && if3.mem_we) begin
      wr_cnt3 <= wr_cnt3 + 1;
      for (int i = 0; i < 4; i++)
        if (if3.mem_be[i]) mem3[if3.mem_addr][8*i +: 8] <= if3.mem_wdata[8*i +: 8];
    end
  end
  assign if3.mem_rdata = p3[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers one request, times the response from the accept edge, then consumes it.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] rd, input int exp_lat,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int   n;
    int   en_cnt;
    rsp_t r;
    sb.push_back('{rdata: exp_rdata, rd: rd, err: exp_err});
    check("req_ready_idle", {31'd0, m_req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b011;
    req_addr = $urandom; req_wdata = $urandom; req_rd = 5'h1f;
    n = 1;
    en_cnt = 0;
    while (!m_rsp_valid && n < 20) begin
      if (m_mem_en) begin
        en_cnt++;
        last_be = m_mem_be; last_wdata = m_mem_wdata; last_maddr = m_mem_addr; last_we = m_mem_we;
      end
      @(posedge clk); #1;
      n++;
    end
    check("rsp_latency", n, exp_lat);
    check("mem_en_cycles", en_cnt, exp_err ? 0 : 1);
    r = sb.pop_front();
    check("rsp_rdata", m_rsp_rdata, r.rdata);
    check("rsp_rd", {27'd0, m_rsp_rd}, {27'd0, r.rd});
    check("rsp_err", {31'd0, m_rsp_err}, {31'd0, r.err});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'd0, m_rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rsp_t r;
    int   w0;
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; rsp_ready = 1'b0;
    rst_n1 = 1'b0; rst_n3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, m_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("rst_mem_en", {31'd0, m_mem_en}, 32'd0);
    check("rst_mem_be", {28'd0, m_mem_be}, 32'd0);
    check("rst_mem_addr", {22'd0, m_mem_addr}, 32'd0);
    check("rst_mem_wdata", m_mem_wdata, 32'd0);
    check("rst_rsp_rdata", m_rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, m_rsp_err}, 32'd0);
    rst_n1 = 1'b1; rst_n3 = 1'b1;
    @(posedge clk); #1;

    // Word store then load back.
    xact(1'b1, F3_W, 32'h0, 32'h0000_0539, 5'd1, 2, 32'h0, 1'b0);
    check("sw_be", {28'd0, last_be}, 32'hf);
    check("sw_wdata", last_wdata, 32'h0000_0539);
    check("sw_we", {31'd0, last_we}, 32'd1);
    xact(1'b0, F3_W, 32'h0, 32'h0, 5'd7, 3, 32'h0000_0539, 1'b0);

    // Lane extraction and extension from word 1.
    xact(1'b1, F3_W, 32'h4, 32'h80FF_7F01, 5'd2, 2, 32'h0, 1'b0);
    xact(1'b0, F3_B,  32'h5, 32'h0, 5'd3, 3, 32'h0000_007F, 1'b0);
    xact(1'b0, F3_B,  32'h7, 32'h0, 5'd4, 3, 32'hFFFF_FF80, 1'b0);
    xact(1'b0, F3_BU, 32'h7, 32'h0, 5'd5, 3, 32'h0000_0080, 1'b0);
    xact(1'b0, F3_H,  32'h6, 32'h0, 5'd6, 3, 32'hFFFF_80FF, 1'b0);
    xact(1'b0, F3_HU, 32'h6, 32'h0, 5'd8, 3, 32'h0000_80FF, 1'b0);

    // Sub-word stores.
    xact(1'b1, F3_B, 32'h9, 32'h0000_00AB, 5'd9, 2, 32'h0, 1'b0);
    check("sb_be", {28'd0, last_be}, 32'h2);
    check("sb_wdata", last_wdata, 32'hABAB_ABAB);
    check("sb_maddr", {22'd0, last_maddr}, 32'd2);
    xact(1'b1, F3_H, 32'hA, 32'hFFFF_1234, 5'd10, 2, 32'h0, 1'b0);
    check("sh_be", {28'd0, last_be}, 32'hc);
    check("sh_wdata", last_wdata, 32'h1234_1234);
    xact(1'b0, F3_W, 32'h8, 32'h0, 5'd11, 3, 32'h1234_AB00, 1'b0);

    // Misaligned half and address wrap.
    xact(1'b1, F3_W, 32'h0, 32'hBEEF_1234, 5'd12, 2, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    xact(1'b0, F3_H, 32'h3, 32'h0, 5'd13, 1, 32'h0, 1'b1);
    xact(1'b1, F3_W, 32'h2, 32'h5555_5555, 5'd14, 1, 32'h0, 1'b1);
`else
    xact(1'b0, F3_H, 32'h3, 32'h0, 5'd13, 3, 32'hFFFF_BEEF, 1'b0);
    check("lh_mis_maddr", {22'd0, last_maddr}, 32'd0);
`endif
    xact(1'b0, F3_W, 32'h0000_1000, 32'h0, 5'd15, 3, 32'hBEEF_1234, 1'b0);
    check("wrap_maddr", {22'd0, last_maddr}, 32'd0);

    // Illegal funct3 load, response held while execute stalls.
    sb.push_back('{rdata: 32'h0, rd: 5'd16, err: 1'b1});
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 32'h0; req_rd = 5'd16;
    @(posedge clk); #1;
    r = sb.pop_front();
    check("ill_valid_t1", {31'd0, m_rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, m_rsp_valid}, 32'd1);
      check("hold_err", {31'd0, m_rsp_err}, {31'd0, r.err});
      check("hold_rdata", m_rsp_rdata, r.rdata);
      check("hold_rd", {27'd0, m_rsp_rd}, {27'd0, r.rd});
      check("hold_req_ready", {31'd0, m_req_ready}, 32'd0);
      check("hold_mem_en", {31'd0, m_mem_en}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("ill_release_ready", {31'd0, m_req_ready}, 32'd1);
    xact(1'b1, F3_BU, 32'h0, 32'h0, 5'd17, 1, 32'h0, 1'b1);

    // MEM_LAT=3 instance: latency and async reset mid-operation.
    sel = 1'b1;
    xact(1'b1, F3_W, 32'h10, 32'h55AA_55AA, 5'd1, 2, 32'h0, 1'b0);
    xact(1'b0, F3_W, 32'h10, 32'h0, 5'd8, 5, 32'h55AA_55AA, 1'b0);

    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_rd = 5'd8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n3 = 1'b0;
    #1;
    check("rstw_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("rstw_req_ready", {31'd0, m_req_ready}, 32'd1);
    check("rstw_mem_en", {31'd0, m_mem_en}, 32'd0);
    @(posedge clk); #1;
    rst_n3 = 1'b1;
    @(posedge clk); #1;
    check("rstw_post_valid", {31'd0, m_rsp_valid}, 32'd0);

    w0 = wr_cnt3;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h10;
    req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rsti_issue_en", {31'd0, m_mem_en}, 32'd1);
    rst_n3 = 1'b0;
    #1;
    check("rsti_mem_en_drop", {31'd0, m_mem_en}, 32'd0);
    @(posedge clk); #1;
    rst_n3 = 1'b1;
    @(posedge clk); #1;
    check("rsti_no_write", wr_cnt3, w0);
    xact(1'b0, F3_W, 32'h10, 32'h0, 5'd9, 5, 32'h55AA_55AA, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
